// File: rtl/ieee754_conv_sched.sv
// ieee754_conv_sched: round-robin scheduler sharing one combinational fixed-to-float converter.
// Optional macro IEEE_SCHED_ZERO_FIX_EN forces a 0.0 operand to return +0.0.
module ieee754_conv_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_int,
    input  logic [NREQ*32-1:0]   req_frac,
    output logic [31:0]          conv_int,
    output logic [31:0]          conv_frac,
    input  logic [31:0]          conv_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] last;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] cand;
    logic           found;
    logic [31:0]    sel_int, sel_frac;
    logic [31:0]    conv_sel;

    // First valid requester searching upward from last+1, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        grant = last;
        cand  = last;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(last) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        sel_int  = '0;
        sel_frac = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant == IDW'(k)) begin
                sel_int  = req_int[k*32 +: 32];
                sel_frac = req_frac[k*32 +: 32];
            end
        end
    end

    always_comb begin
`ifdef IEEE_SCHED_ZERO_FIX_EN
        conv_sel = (conv_int == '0 && conv_frac == '0) ? '0 : conv_result;
`else
        conv_sel = conv_result;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // req_ready is gated by rst_n so it reads zero while reset is asserted.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt        = CONV;
                    req_ready[grant] = rst_n;
                end
            end
            CONV:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_int  <= '0;
            conv_frac <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            last      <= IDW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        conv_int  <= sel_int;
                        conv_frac <= sel_frac;
                        rsp_id    <= grant;
                        last      <= grant;
                    end
                end
                CONV: begin
                    rsp_data  <= conv_sel;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ieee754_conv_sched.sv
// Directed bench for ieee754_conv_sched with a behavioural 32.32-to-float converter model.
module tb_ieee754_conv_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_int, req_frac;
    logic [31:0]  conv_int, conv_frac, conv_result;
    logic         rsp_valid, rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         busy;

    logic [31:0]  op_int [4];
    logic [31:0]  op_frac[4];

    int tests = 0;
    int fails = 0;

`ifdef IEEE_SCHED_ZERO_FIX_EN
    localparam logic [31:0] ZERO_EXP = 32'h00000000;
`else
    localparam logic [31:0] ZERO_EXP = 32'h3F800000;
`endif

    always #5 clk = ~clk;

    assign req_int  = {op_int[3],  op_int[2],  op_int[1],  op_int[0]};
    assign req_frac = {op_frac[3], op_frac[2], op_frac[1], op_frac[0]};

    // Shared converter: truncating 32.32 -> single; zero maps to 1.0 as the ALU instance does.
    function automatic logic [31:0] fx2fp(input logic [31:0] i, input logic [31:0] f);
        logic [63:0] v;
        logic [63:0] m;
        int p;
        v = {i, f};
        p = 0;
        if (v == 64'd0) return 32'h3F800000;
        for (int b = 0; b < 64; b++) if (v[b]) p = b;
        m = v << (63 - p);
        return {1'b0, 8'(p + 95), m[62:40]};
    endfunction

    assign conv_result = fx2fp(conv_int, conv_frac);

    ieee754_conv_sched #(.NREQ(4), .IDW(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_int     (req_int),
        .req_frac    (req_frac),
        .conv_int    (conv_int),
        .conv_frac   (conv_frac),
        .conv_result (conv_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction for requester k, rsp_ready assumed high.
    task automatic serve(input int k, input logic [31:0] exp, input bit drop);
        #1;
        check("grant_ready", 64'(req_ready), 64'(4'b0001 << k));
        step();
        if (drop) req_valid[k] = 1'b0;
        #1;
        check("conv_busy", 64'(busy), 64'd1);
        check("conv_ready_zero", 64'(req_ready), 64'd0);
        check("conv_rsp_valid", 64'(rsp_valid), 64'd0);
        check("conv_int", 64'(conv_int), 64'(op_int[k]));
        check("conv_frac", 64'(conv_frac), 64'(op_frac[k]));
        step();
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_data", 64'(rsp_data), 64'(exp));
        check("rsp_id", 64'(rsp_id), 64'(k));
        step();
        check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op_int[k]  = '0;
            op_frac[k] = '0;
        end
        step();
        step();
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_conv_int", 64'(conv_int), 64'd0);
        check("rst_conv_frac", 64'(conv_frac), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        step();

        // Single request from requester 1: 5.0
        op_int[1] = 32'd5;
        req_valid = 4'b0010;
        serve(1, 32'h40A00000, 1'b1);

        // All four at once after reset: grants 0,1,2,3 each 3 cycles apart
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op_int[k]  = 32'd1;
            op_frac[k] = 32'h80000000;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) serve(k, 32'h3FC00000, 1'b1);

        // Backpressure on requester 2 (2.0) while 0 and 1 wait
        op_int[2]  = 32'd2; op_frac[2] = '0;
        op_int[0]  = 32'd3; op_frac[0] = '0;
        op_int[1]  = 32'd0; op_frac[1] = 32'h80000000;
        rsp_ready  = 1'b0;
        req_valid  = 4'b0100;
        #1;
        check("bp_grant", 64'(req_ready), 64'h4);
        step();
        req_valid = 4'b0011;
        #1;
        check("bp_conv_ready", 64'(req_ready), 64'd0);
        step();
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_data", 64'(rsp_data), 64'h40000000);
            check("stall_id", 64'(rsp_id), 64'd2);
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_busy", 64'(busy), 64'd1);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_release_valid", 64'(rsp_valid), 64'd0);
        serve(0, 32'h40400000, 1'b1);
        serve(1, 32'h3F000000, 1'b1);

        // Zero operand on requester 3
        op_int[3] = '0; op_frac[3] = '0;
        req_valid = 4'b1000;
        serve(3, ZERO_EXP, 1'b1);

        // Reset during CONV discards the in-flight result
        op_int[2] = 32'd7; op_frac[2] = '0;
        req_valid = 4'b0100;
        #1;
        check("mid_grant", 64'(req_ready), 64'h4);
        step();
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_data", 64'(rsp_data), 64'd0);
        check("mid_rst_id", 64'(rsp_id), 64'd0);
        check("mid_rst_conv_int", 64'(conv_int), 64'd0);
        check("mid_rst_conv_frac", 64'(conv_frac), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        step();
        check("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
        step();
        check("mid_rst_no_rsp2", 64'(rsp_valid), 64'd0);
        op_int[0] = 32'd3; op_frac[0] = '0;
        req_valid = 4'b0101;
        rst_n = 1'b1;
        serve(0, 32'h40400000, 1'b1);
        serve(2, 32'h40E00000, 1'b1);

        // Requester 3 continuous, then requester 0 joins: 3,0,3,0
        op_int[3] = 32'd2; op_frac[3] = '0;
        op_int[0] = 32'd5; op_frac[0] = '0;
        req_valid = 4'b1000;
        serve(3, 32'h40000000, 1'b0);
        req_valid = 4'b1001;
        serve(0, 32'h40A00000, 1'b0);
        serve(3, 32'h40000000, 1'b0);
        serve(0, 32'h40A00000, 1'b0);
        req_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
